alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 121 ++++++++++++
 tb/tb_alu_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU: single-cycle logic/arith ops, 32-cycle MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_mul = 3'b011;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;
    localparam logic [5:0] c_last_iter = 6'd31;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_pp;
    logic [5:0]  r_cnt;

    logic [31:0] w_or;
    logic [31:0] w_alu;
    logic [31:0] w_pp_next;

    assign w_or = a | b;

    always_comb begin
        w_alu = 32'd0;
        case (op)
            c_op_and: w_alu = a & b;
            c_op_or:  w_alu = w_or;
            c_op_add: w_alu = a + b;
            c_op_sub: w_alu = a - b;
            c_op_slt: w_alu = {31'd0, ($signed(a) < $signed(b))};
            default:  w_alu = 32'd0;
        endcase
    end

    // Multiplicand is pre-shifted each iteration, so the add is always aligned.
    assign w_pp_next = r_pp + (r_mplier[0] ? r_mcand : 32'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= 32'd0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_pp     <= 32'd0;
            r_cnt    <= 6'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (op == c_op_mul) begin
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_pp     <= 32'd0;
                            r_cnt    <= 6'd0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == 32'd0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_pp     <= w_pp_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 6'd1;
                    if (r_cnt == c_last_iter) begin
                        r_result <= w_pp_next;
                        r_zero   <= (w_pp_next == 32'd0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; busy/done exclusivity every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    endtask

    task automatic single_op(input string tag, input logic [2:0] o,
                             input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] exp);
        start = 1'b1; op = o; a = va; b = vb;
        step();
        check({tag, "_result"}, result, exp);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Issue MUL, optionally disturb inputs while busy; returns in the done cycle.
    task automatic run_mul(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp, input bit perturb);
        int busy_cycles;
        start = 1'b1; op = 3'b011; a = va; b = vb;
        step();
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_start"}, {31'd0, done}, 32'd0);
        busy_cycles = 1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            if (perturb) begin
                start = 1'b1; op = 3'b001;
                a = 32'h1234_5678 + i; b = 32'hDEAD_0000;
            end
            step();
            if (busy) busy_cycles++;
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, busy_cycles, 32);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    endtask

    initial begin
        int done_pulses;
        rst_n = 1'b0; start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0;
        step();
        step();
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // First edge after reset release accepts the request.
        rst_n = 1'b1;
        single_op("or", 3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF);
        start = 1'b0;
        step();
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_hold", result, 32'hFFFF_00FF);
        single_op("and", 3'b000, 32'hF0F0_0000, 32'h0F0F_00FF, 32'h0000_0000);
        single_op("add", 3'b010, 32'd3, 32'd4, 32'd7);
        single_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single_op("sub", 3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE);
        single_op("inv", 3'b100, 32'd5, 32'd9, 32'd0);
        single_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single_op("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0);
        single_op("inv2", 3'b101, 32'd1, 32'd1, 32'd0);

        // MUL with input disturbance during busy
        run_mul("mul", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b1);
        step();
        check("mul_no_second_busy", {31'd0, busy}, 32'd0);
        check("mul_no_second_done", {31'd0, done}, 32'd0);
        check("mul_hold", result, 32'h0005_000F);

        run_mul("mul_wrap0", 32'h8000_0000, 32'd2, 32'd0, 1'b0);
        step();
        run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

        // Back-to-back: OR issued in the MUL done cycle
        single_op("b2b_or", 3'b001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0);
        start = 1'b0;
        step();
        check("b2b_done_end", {31'd0, done}, 32'd0);

        // Reset at cycle 10 of busy
        start = 1'b1; op = 3'b011; a = 32'd3; b = 32'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("rstmid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_result", result, 32'd0);
        check("rstmid_zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) done_pulses++;
        end
        check("rstmid_no_done", done_pulses, 0);
        check("rstmid_result_hold", result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
